// File: rtl/bcd_scan_display_if.sv
// Bundles the conversion request/response signals and the display bus of
// bcd_scan_display. The master drives the binary value and load strobe; the
// slave (the display block) returns status, committed digits and the
// multiplexed segment/anode lines.
interface bcd_scan_display_if #(
    parameter int N_IN  = 14,
    parameter int N_DIG = 4
);
    logic [N_IN-1:0]    bin_in;
    logic               load;
    logic               busy;
    logic               done;
    logic               ovf;
    logic [4*N_DIG-1:0] bcd_out;
    logic [0:6]         seg;
    logic [N_DIG-1:0]   an;

    modport master (
        output bin_in, load,
        input  busy, done, ovf, bcd_out, seg, an
    );

    modport slave (
        input  bin_in, load,
        output busy, done, ovf, bcd_out, seg, an
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock)
// driving N_DIG common-anode 7-segment displays over one shared,
// time-multiplexed segment bus. Digits are committed only at the end of a
// conversion, so the display never shows a partial result.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank zero digits above
// the highest non-zero digit (units and overflow dashes are never blanked).
module bcd_scan_display #(
    parameter int N_IN     = 14,
    parameter int N_DIG    = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    bcd_scan_display_if.slave bus
);
    localparam int SW = 4*N_DIG + 4;
    localparam int CW = $clog2(N_IN + 1);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [32:0] OVF_LIMIT = 33'(10**N_DIG);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    shift_q, shift_d;
    logic [SW-1:0]      scratch_q, scratch_d;
    logic [SW-1:0]      adj;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [4*N_DIG-1:0] bcd_q, bcd_d;

    logic [DW-1:0]      div_q, div_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [0:6]         seg_q, seg_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [3:0]         nibble;
    logic               lead_zero;

    // Active-low segment pattern for one BCD nibble; 10-15 are blank.
    function automatic logic [0:6] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Conversion FSM: latch on load, N_IN add-3/shift steps, then commit.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        adj        = scratch_q;
        for (int i = 0; i < N_DIG + 1; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d    = bus.bin_in;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (33'(bus.bin_in) >= OVF_LIMIT);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_IN - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bcd_d   = scratch_q[4*N_DIG-1:0];
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Conversion state and committed result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    // Scan divider: on each wrap light digit idx and decode its nibble together.
    always_comb begin
        div_d  = div_q + DW'(1);
        idx_d  = idx_q;
        seg_d  = seg_q;
        an_d   = an_q;
        nibble = bcd_q[4*int'(idx_q) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero = (idx_q != '0) && ((bcd_q >> (4*int'(idx_q))) == '0);
`else
        lead_zero = 1'b0;
`endif
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + IW'(1);
            an_d  = ~(N_DIG'(1) << idx_q);
            if (ovf_q) begin
                seg_d = 7'b1111110;
            end else if (lead_zero) begin
                seg_d = 7'b1111111;
            end else begin
                seg_d = seg_decode(nibble);
            end
        end
    end

    // Scan registers; seg and an update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= 7'b1111111;
            an_q  <= '1;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.bcd_out = bcd_q;
    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
endmodule
